alu_regfile: RTL and testbench

ALU_REGFILE -- requirements
Module: alu_regfile

---
 rtl/alu_regfile_if.sv | 33 +++
 rtl/alu_regfile.sv | 99 +++++++++
 tb/tb_alu_regfile.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_regfile_if.sv
// Bus bundle for alu_regfile: two write ports, two read ports and the ALU controls/results.
// The block has no handshake; every input is sampled each cycle and outputs are combinational.
interface alu_regfile_if #(
  parameter int WIDTH_WORD = 8,
  parameter int WIDTH_SEG  = 4
);
  logic                  write0;
  logic                  write1;
  logic [WIDTH_SEG-1:0]  dstreg0;
  logic [WIDTH_WORD-1:0] dstval0;
  logic [WIDTH_SEG-1:0]  dstreg1;
  logic [WIDTH_WORD-1:0] dstval1;
  logic [WIDTH_SEG-1:0]  argreg0;
  logic [WIDTH_WORD-1:0] argval0;
  logic [WIDTH_SEG-1:0]  argreg1;
  logic [WIDTH_WORD-1:0] argval1;
  logic                  alu_mode;
  logic [2:0]            alu_func;
  logic [WIDTH_WORD-1:0] alu_result;
  logic                  alu_carry;

  modport master (
    output write0, write1, dstreg0, dstval0, dstreg1, dstval1,
    output argreg0, argreg1, alu_mode, alu_func,
    input  argval0, argval1, alu_result, alu_carry
  );

  modport slave (
    input  write0, write1, dstreg0, dstval0, dstreg1, dstval1,
    input  argreg0, argreg1, alu_mode, alu_func,
    output argval0, argval1, alu_result, alu_carry
  );
endinterface

// File: rtl/alu_regfile.sv
// 16-entry two-write/two-read register file feeding a combinational ALU and test-flag unit.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module alu_regfile #(
  parameter int WIDTH_WORD = 8,
  parameter int WIDTH_SEG  = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_regfile_if.slave bus
);
  localparam int NREG = 1 << WIDTH_SEG;

  logic [WIDTH_WORD-1:0] regs_q [NREG];
  logic [WIDTH_WORD-1:0] regs_d [NREG];
  logic                  wr0_en;
  logic                  wr1_en;

  // Enables are masked by reset so a bypassed read cannot leak write data while cleared.
  assign wr0_en = bus.write0 & ~rst;
  assign wr1_en = bus.write1 & ~rst;

  // Port 1 is applied last so it wins a same-index collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr0_en) regs_d[bus.dstreg0] = bus.dstval0;
    if (wr1_en) regs_d[bus.dstreg1] = bus.dstval1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  logic [WIDTH_WORD-1:0] op_a;
  logic [WIDTH_WORD-1:0] op_b;

`ifdef REGFILE_BYPASS_EN
  assign op_a = regs_d[bus.argreg0];
  assign op_b = regs_d[bus.argreg1];
`else
  assign op_a = regs_q[bus.argreg0];
  assign op_b = regs_q[bus.argreg1];
`endif

  assign bus.argval0 = op_a;
  assign bus.argval1 = op_b;

  logic [WIDTH_WORD:0]   sum_w;
  logic [WIDTH_WORD:0]   diff_w;
  logic [WIDTH_WORD-1:0] res_c;
  logic                  car_c;

  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  // The extra MSB of the subtraction is the unsigned borrow.
  assign diff_w = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    res_c = '0;
    car_c = 1'b0;
    if (bus.alu_mode) begin
      case (bus.alu_func)
        3'b000: begin res_c = sum_w[WIDTH_WORD-1:0];  car_c = sum_w[WIDTH_WORD];  end
        3'b001: begin res_c = diff_w[WIDTH_WORD-1:0]; car_c = diff_w[WIDTH_WORD]; end
        3'b010: res_c = op_a | op_b;
        3'b011: res_c = ~op_a;
        3'b100: res_c = op_a;
        3'b101: res_c = op_a & op_b;
        3'b110: res_c = op_a ^ op_b;
        3'b111: begin res_c = {op_a[WIDTH_WORD-2:0], 1'b0}; car_c = op_a[WIDTH_WORD-1]; end
        default: begin res_c = '0; car_c = 1'b0; end
      endcase
    end else begin
      case (bus.alu_func)
        3'b000: car_c = (op_a == op_b);
        3'b001: car_c = (op_a < op_b);
        3'b010: car_c = (op_a != '0);
        3'b011: car_c = (op_a == '0);
        3'b100: car_c = op_a[WIDTH_WORD-1];
        3'b101: car_c = op_a[0];
        3'b110: car_c = 1'b1;
        3'b111: car_c = 1'b0;
        default: car_c = 1'b0;
      endcase
    end
  end

  assign bus.alu_result = res_c;
  assign bus.alu_carry  = car_c;

endmodule

// File: tb/tb_alu_regfile.sv
// Directed plus randomized bench for alu_regfile with an arithmetic reference model.
module tb_alu_regfile;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   mem [16];

  alu_regfile_if #(.WIDTH_WORD(8), .WIDTH_SEG(4)) bus ();

  alu_regfile #(.WIDTH_WORD(8), .WIDTH_SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_w(input bit e0, input int r0, input int v0,
                       input bit e1, input int r1, input int v1);
    bus.write0 = e0; bus.dstreg0 = 4'(r0); bus.dstval0 = 8'(v0);
    bus.write1 = e1; bus.dstreg1 = 4'(r1); bus.dstval1 = 8'(v1);
  endtask

  task automatic set_r(input int a0, input int a1, input int mode, input int func);
    bus.argreg0 = 4'(a0); bus.argreg1 = 4'(a1);
    bus.alu_mode = 1'(mode); bus.alu_func = 3'(func);
  endtask

  // reference model
  function automatic int model_read(input int idx);
    int v;
    v = mem[idx];
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      if (bus.write0 && int'(bus.dstreg0) == idx) v = int'(bus.dstval0);
      if (bus.write1 && int'(bus.dstreg1) == idx) v = int'(bus.dstval1);
    end
`endif
    return v;
  endfunction

  task automatic alu_model(input int a, input int b, input int mode, input int func,
                           output int res, output int car);
    res = 0; car = 0;
    if (mode == 1) begin
      case (func)
        0: begin res = (a + b) % 256; car = (a + b > 255) ? 1 : 0; end
        1: begin res = (a - b + 256) % 256; car = (a < b) ? 1 : 0; end
        2: res = a | b;
        3: res = 255 - a;
        4: res = a;
        5: res = a & b;
        6: res = a ^ b;
        default: begin res = (a * 2) % 256; car = (a >= 128) ? 1 : 0; end
      endcase
    end else begin
      case (func)
        0: car = (a == b) ? 1 : 0;
        1: car = (a < b) ? 1 : 0;
        2: car = (a != 0) ? 1 : 0;
        3: car = (a == 0) ? 1 : 0;
        4: car = (a >= 128) ? 1 : 0;
        5: car = a % 2;
        6: car = 1;
        default: car = 0;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    int a, b, res, car;
    a = model_read(int'(bus.argreg0));
    b = model_read(int'(bus.argreg1));
    alu_model(a, b, int'(bus.alu_mode), int'(bus.alu_func), res, car);
    chk({tag, ".argval0"}, 32'(bus.argval0), 32'(a));
    chk({tag, ".argval1"}, 32'(bus.argval1), 32'(b));
    chk({tag, ".result"}, 32'(bus.alu_result), 32'(res));
    chk({tag, ".carry"}, 32'(bus.alu_carry), 32'(car));
  endtask

  // advance one clock: commit modeled writes at the edge, return at the next negedge + 1
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (bus.write0) mem[bus.dstreg0] = int'(bus.dstval0);
      if (bus.write1) mem[bus.dstreg1] = int'(bus.dstval1);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int old4;
    total = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    rst = 1'b1;
    set_w(0, 0, 0, 0, 0, 0);
    set_r(0, 0, 1, 0);
    #2;

    // reset state: every index reads zero
    for (int i = 0; i < 16; i++) begin
      set_r(i, 15 - i, 1, 0);
      #1;
      chk("rst_read0", 32'(bus.argval0), 32'h0);
      chk("rst_read1", 32'(bus.argval1), 32'h0);
    end
    chk("rst_result", 32'(bus.alu_result), 32'h0);
    chk("rst_carry", 32'(bus.alu_carry), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    #1;

    // r1=0, r2=1, then ADD r2+r1 and store into r3
    set_w(1, 1, 0, 0, 0, 0); tick();
    set_w(1, 2, 1, 0, 0, 0); tick();
    set_w(0, 0, 0, 0, 0, 0);
    set_r(2, 1, 1, 0); #1;
    chk("add_r2r1_res", 32'(bus.alu_result), 32'h1);
    chk("add_r2r1_car", 32'(bus.alu_carry), 32'h0);
    set_w(1, 3, int'(bus.alu_result), 0, 0, 0); tick();
    set_w(0, 0, 0, 0, 0, 0);
    set_r(3, 0, 1, 4); #1;
    chk("r3_readback", 32'(bus.argval0), 32'h1);

    // ADD overflow and SUB borrow
    set_w(1, 6, 8'hFF, 1, 7, 8'h01); tick();
    set_w(1, 8, 8'h01, 1, 9, 8'h02); tick();
    set_w(0, 0, 0, 0, 0, 0);
    set_r(6, 7, 1, 0); #1;
    chk("add_ovf_res", 32'(bus.alu_result), 32'h00);
    chk("add_ovf_car", 32'(bus.alu_carry), 32'h1);
    set_r(8, 9, 1, 1); #1;
    chk("sub_brw_res", 32'(bus.alu_result), 32'hFF);
    chk("sub_brw_car", 32'(bus.alu_carry), 32'h1);

    // dual write, then same-index collision
    set_w(1, 14, 8'h34, 1, 15, 8'h12); tick();
    set_w(0, 0, 0, 0, 0, 0);
    set_r(14, 15, 1, 4); #1;
    chk("dual_r14", 32'(bus.argval0), 32'h34);
    chk("dual_r15", 32'(bus.argval1), 32'h12);
    set_w(1, 5, 8'hAA, 1, 5, 8'h55); tick();
    set_w(0, 0, 0, 0, 0, 0);
    set_r(5, 5, 1, 4); #1;
    chk("collide_r5", 32'(bus.argval0), 32'h55);

    // test-flag path
    set_w(1, 10, 7, 1, 11, 3); tick();
    set_w(0, 0, 0, 0, 0, 0);
    set_r(10, 10, 0, 0); #1;
    chk("teq_car", 32'(bus.alu_carry), 32'h1);
    chk("teq_res", 32'(bus.alu_result), 32'h0);
    set_r(11, 10, 0, 1); #1;
    chk("tlt_car", 32'(bus.alu_carry), 32'h1);

    // same-cycle read of a register being written
    old4 = mem[4];
    set_w(1, 4, 8'h09, 0, 0, 0);
    set_r(4, 0, 1, 4); #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_cycle", 32'(bus.argval0), 32'h09);
`else
    chk("byp_same_cycle", 32'(bus.argval0), 32'(old4));
`endif
    tick();
    set_w(0, 0, 0, 0, 0, 0); #1;
    chk("byp_after_edge", 32'(bus.argval0), 32'h09);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int r0, r1;
      r0 = $urandom_range(0, 15);
      r1 = ($urandom_range(0, 3) == 0) ? r0 : $urandom_range(0, 15);
      set_w($urandom_range(0, 1), r0, $urandom_range(0, 255),
            $urandom_range(0, 1), r1, $urandom_range(0, 255));
      set_r($urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 7));
      #1;
      check_all("rand_pre");
      tick();
    end

    // mid-run asynchronous reset clears without a clock edge
    set_w(1, 7, 8'h5A, 0, 0, 0); tick();
    set_w(0, 0, 0, 0, 0, 0);
    set_r(7, 7, 1, 4); #1;
    chk("pre_rst_r7", 32'(bus.argval0), 32'h5A);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    #1;
    chk("async_rst_r7", 32'(bus.argval0), 32'h0);
    chk("async_rst_res", 32'(bus.alu_result), 32'h0);
    for (int i = 0; i < 16; i++) begin
      set_r(i, i, 0, 0);
      #0.5;
      check_all("midrst");
    end

    // writes ignored while held in reset, accepted on first edge after release
    @(negedge clk); #1;
    set_w(1, 3, 8'h77, 0, 0, 0);
    set_r(3, 3, 1, 4);
    tick();
    chk("rst_write_ignored", 32'(bus.argval0), 32'h0);
    rst = 1'b0;
    tick();
    chk("first_write_after_rst", 32'(bus.argval0), 32'h77);
    set_w(0, 0, 0, 0, 0, 0); #1;
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
